// File: rtl/i2c_slave_regs.sv
// I2C slave bridging the bus to a simple register port: pointer write, auto-incrementing
// burst writes, and pointer-based burst reads with repeated-START support.
module i2c_slave_regs #(
   parameter logic [6:0] I2C_ADDR = 7'h6A
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] reg_ptr,
   input  logic [7:0] rd_data,
   output logic       wr_strobe,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       busy
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK, WAIT_STOP
   } state_t;

   state_t     state, state_nxt;
   logic [2:0] scl_sync, sda_sync;
   logic       scl_rise, scl_fall, start_det, stop_det, sda_bit, byte_full, addr_hit;
   logic [3:0] bit_cnt, bit_cnt_nxt;
   logic [7:0] shift, shift_nxt, reg_ptr_nxt, wr_addr_nxt, wr_data_nxt;
   logic       sda_oe_nxt, busy_nxt, wr_pend, wr_pend_nxt, wr_strobe_nxt, rw, rw_nxt;

   // Two synchronizer flops plus one edge-detect flop per line; idle bus reads as high.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         scl_sync <= 3'b111;
         sda_sync <= 3'b111;
      end else begin
         scl_sync <= {scl_sync[1:0], scl_in};
         sda_sync <= {sda_sync[1:0], sda_in};
      end
   end

   assign scl_rise  = scl_sync[1] & ~scl_sync[2];
   assign scl_fall  = ~scl_sync[1] & scl_sync[2];
   assign start_det = ~sda_sync[1] & sda_sync[2] & scl_sync[1] & scl_sync[2];
   assign stop_det  = sda_sync[1] & ~sda_sync[2] & scl_sync[1] & scl_sync[2];
   assign sda_bit   = sda_sync[1];
   assign byte_full = (bit_cnt == 4'd8);
   assign addr_hit  = (shift[7:1] == I2C_ADDR);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (stop_det) state_nxt = IDLE;
      else if (start_det) state_nxt = ADDR;
      else begin
         case (state)
            IDLE, WAIT_STOP: state_nxt = state;
            ADDR:      if (scl_fall && byte_full) state_nxt = addr_hit ? ADDR_ACK : WAIT_STOP;
            ADDR_ACK:  if (scl_fall) state_nxt = rw ? RDATA : PTR;
            PTR:       if (scl_fall && byte_full) state_nxt = PTR_ACK;
            PTR_ACK:   if (scl_fall) state_nxt = WDATA;
            WDATA:     if (scl_fall && byte_full) state_nxt = WDATA_ACK;
            WDATA_ACK: if (scl_fall) state_nxt = WDATA;
            RDATA:     if (scl_fall && byte_full) state_nxt = RD_MACK;
            RD_MACK: begin
               if (scl_rise && sda_bit) state_nxt = WAIT_STOP;
               else if (scl_fall)       state_nxt = RDATA;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Datapath and registered outputs; sda_oe moves only on a detected SCL fall, STOP or reset.
   always_comb begin
      sda_oe_nxt    = sda_oe;
      busy_nxt      = busy;
      reg_ptr_nxt   = reg_ptr;
      shift_nxt     = shift;
      bit_cnt_nxt   = bit_cnt;
      rw_nxt        = rw;
      wr_pend_nxt   = 1'b0;
      wr_strobe_nxt = wr_pend;
      wr_addr_nxt   = wr_addr;
      wr_data_nxt   = wr_data;
      if (wr_pend) begin
         wr_addr_nxt = reg_ptr;
         wr_data_nxt = shift;
      end
      if (stop_det) begin
         sda_oe_nxt  = 1'b0;
         busy_nxt    = 1'b0;
         bit_cnt_nxt = 4'd0;
      end else if (start_det) begin
         bit_cnt_nxt = 4'd0;
      end else begin
         case (state)
            ADDR, PTR, WDATA: begin
               if (scl_rise && !byte_full) begin
                  shift_nxt   = {shift[6:0], sda_bit};
                  bit_cnt_nxt = bit_cnt + 4'd1;
                  if (state == WDATA && bit_cnt == 4'd7) wr_pend_nxt = 1'b1;
               end
               if (scl_fall) begin
                  if (!byte_full) begin
                     sda_oe_nxt = 1'b0;
                  end else begin
                     bit_cnt_nxt = 4'd0;
                     if (state == ADDR) begin
                        sda_oe_nxt = addr_hit;
                        busy_nxt   = addr_hit;
                        rw_nxt     = shift[0];
                     end else begin
                        sda_oe_nxt = 1'b1;
                        if (state == PTR) reg_ptr_nxt = shift;
                     end
                  end
               end
            end
            ADDR_ACK: if (scl_fall) begin
               bit_cnt_nxt = 4'd0;
               shift_nxt   = rd_data;
               sda_oe_nxt  = rw ? ~rd_data[7] : 1'b0;
            end
            PTR_ACK: if (scl_fall) begin
               sda_oe_nxt  = 1'b0;
               bit_cnt_nxt = 4'd0;
            end
            WDATA_ACK: if (scl_fall) begin
               sda_oe_nxt  = 1'b0;
               bit_cnt_nxt = 4'd0;
               reg_ptr_nxt = reg_ptr + 8'd1;
            end
            RDATA: begin
               if (scl_rise && !byte_full) bit_cnt_nxt = bit_cnt + 4'd1;
               if (scl_fall) begin
                  if (byte_full) begin
                     sda_oe_nxt  = 1'b0;
                     bit_cnt_nxt = 4'd0;
                  end else begin
                     shift_nxt  = {shift[6:0], 1'b0};
                     sda_oe_nxt = ~shift[6];
                  end
               end
            end
            RD_MACK: begin
               // The pointer moves past every byte sent; only a master ACK continues the burst.
               if (scl_rise) begin
                  reg_ptr_nxt = reg_ptr + 8'd1;
                  if (sda_bit) busy_nxt = 1'b0;
               end
               if (scl_fall) begin
                  shift_nxt   = rd_data;
                  sda_oe_nxt  = ~rd_data[7];
                  bit_cnt_nxt = 4'd0;
               end
            end
            default: bit_cnt_nxt = bit_cnt;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sda_oe    <= 1'b0;
         busy      <= 1'b0;
         reg_ptr   <= 8'd0;
         shift     <= 8'd0;
         bit_cnt   <= 4'd0;
         rw        <= 1'b0;
         wr_pend   <= 1'b0;
         wr_strobe <= 1'b0;
         wr_addr   <= 8'd0;
         wr_data   <= 8'd0;
      end else begin
         sda_oe    <= sda_oe_nxt;
         busy      <= busy_nxt;
         reg_ptr   <= reg_ptr_nxt;
         shift     <= shift_nxt;
         bit_cnt   <= bit_cnt_nxt;
         rw        <= rw_nxt;
         wr_pend   <= wr_pend_nxt;
         wr_strobe <= wr_strobe_nxt;
         wr_addr   <= wr_addr_nxt;
         wr_data   <= wr_data_nxt;
      end
   end

endmodule
